// File: rtl/onehot_enc_pkg.sv
// rtl/onehot_enc_pkg.sv - shared types and helpers for the one-hot event encoder
package onehot_enc_pkg;

    localparam int N_LINES = 16;
    localparam int IDX_W   = 4;

    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [N_LINES-1:0] lines_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } enc_state_t;

    // True when more than one line is set (clearing the lowest set bit leaves something)
    function automatic logic is_multi(input lines_t v);
        return (v & (v - lines_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/onehot_event_encoder_rr_pick.sv
// rtl/onehot_event_encoder_rr_pick.sv - round-robin pick of first set request at/after ptr
module rr_pick
    import onehot_enc_pkg::*;
(
    input  lines_t req,
    input  idx_t   ptr,
    output logic   any,
    output idx_t   idx
);

    idx_t cand;

    // Scan offsets from farthest to nearest so the nearest set line (wrapping) wins last
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            cand = ptr + idx_t'(i);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/onehot_event_encoder.sv
// rtl/onehot_event_encoder.sv - sticky one-hot capture with round-robin index output; optional ONEHOT_ENC_ERR_COUNT_EN
module onehot_event_encoder
    import onehot_enc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d_in,
    input  logic        in_valid,
    output logic [3:0]  out_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] pending,
    output logic        multi_err,
    output logic        overrun,
    input  logic        clr_err
`ifdef ONEHOT_ENC_ERR_COUNT_EN
    ,
    output logic [7:0]  err_count
`endif
);

    enc_state_t state;
    enc_state_t state_next;
    lines_t     cap;
    lines_t     clear_mask;
    lines_t     pending_next;
    logic       accept;
    logic       grant;
    logic       multi_hit;
    logic       overrun_hit;
    logic       pick_any;
    idx_t       pick_idx;
    idx_t       ptr;

    rr_pick u_pick (
        .req (pending),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Capture/clear datapath: a line recaptured on its accept cycle survives as a new event
    always_comb begin
        cap          = in_valid ? d_in : '0;
        accept       = (state == PRESENT) && out_ready;
        clear_mask   = accept ? (lines_t'(1) << out_idx) : '0;
        multi_hit    = is_multi(cap);
        overrun_hit  = |(cap & pending & ~clear_mask);
        pending_next = (pending & ~clear_mask) | cap;
    end

    // Next-state: present one grant, hold until accepted, then a mandatory idle bubble
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant      = 1'b1;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pending flags, output index/valid, round-robin pointer and sticky errors
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            ptr       <= '0;
            multi_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pending <= pending_next;
            if (grant) begin
                out_idx   <= pick_idx;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                ptr <= out_idx + idx_t'(1);
            end
            // A new error in the same cycle as clr_err keeps the flag set
            multi_err <= (multi_err & ~clr_err) | multi_hit;
            overrun   <= (overrun & ~clr_err) | overrun_hit;
        end
    end

`ifdef ONEHOT_ENC_ERR_COUNT_EN
    // Saturating count of erroneous captures, at most one per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (clr_err) begin
            err_count <= (multi_hit | overrun_hit) ? 8'd1 : 8'd0;
        end else if ((multi_hit | overrun_hit) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_onehot_event_encoder.sv
// tb/tb_onehot_event_encoder.sv - self-checking bench for onehot_event_encoder
module tb_onehot_event_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] d_in;
    logic        in_valid;
    logic [3:0]  out_idx;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pending;
    logic        multi_err;
    logic        overrun;
    logic        clr_err;
`ifdef ONEHOT_ENC_ERR_COUNT_EN
    logic [7:0]  err_count;
`endif

    int total = 0;
    int bad   = 0;
    int sb[$];
    logic sb_on = 1'b1;

    typedef struct {
        logic [15:0] d;
        logic        v;
        logic        clr;
        logic [15:0] exp_pending;
        logic        exp_multi;
        logic        exp_overrun;
    } vec_t;

    vec_t vecs[9];

    onehot_event_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .in_valid  (in_valid),
        .out_idx   (out_idx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .pending   (pending),
        .multi_err (multi_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
`ifdef ONEHOT_ENC_ERR_COUNT_EN
        ,
        .err_count (err_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1; d_in = '0; in_valid = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int c;
        for (c = 0; c < 60; c++) begin
            if (sb.size() == 0 && !out_valid && pending == 16'h0) break;
            step();
        end
        chk(name, (sb.size() == 0 && !out_valid && pending == 16'h0) ? 1 : 0, 1);
    endtask

    task automatic capture(input logic [15:0] d);
        d_in = d; in_valid = 1'b1;
        step();
        d_in = '0; in_valid = 1'b0;
    endtask

    // Scoreboard: every accepted index must match the next expected grant
    always @(negedge clk) begin
        if (sb_on && !rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_grant", int'(out_idx), 99);
            end else begin
                chk("grant_idx", int'(out_idx), sb.pop_front());
            end
        end
    end

    initial begin
        vecs[0] = '{16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[2] = '{16'h0006, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[3] = '{16'h0001, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b1};
        vecs[4] = '{16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'h0600, 1'b1, 1'b0, 16'h0601, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 1'b0, 1'b1, 16'h0601, 1'b0, 1'b0};
        vecs[7] = '{16'h0800, 1'b1, 1'b1, 16'h0E01, 1'b0, 1'b0};
        vecs[8] = '{16'h0003, 1'b1, 1'b1, 16'h0E03, 1'b1, 1'b1};

        // Reset held with all lines asserted
        rst = 1'b1; d_in = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b0; clr_err = 1'b0;
        step();
        step();
        chk("rst_pending", int'(pending), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_multi", int'(multi_err), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0; d_in = '0; in_valid = 1'b0;
        step();
        chk("post_rst_pending", int'(pending), 0);

        // Table: captures under backpressure, error flags and clr priority
        reset_dut();
        for (int i = 0; i < 9; i++) begin
            d_in = vecs[i].d; in_valid = vecs[i].v; clr_err = vecs[i].clr;
            step();
            chk($sformatf("tbl%0d_pending", i), int'(pending), int'(vecs[i].exp_pending));
            chk($sformatf("tbl%0d_multi", i), int'(multi_err), int'(vecs[i].exp_multi));
            chk($sformatf("tbl%0d_overrun", i), int'(overrun), int'(vecs[i].exp_overrun));
        end
        d_in = '0; in_valid = 1'b0; clr_err = 1'b0;
        chk("tbl_hold_valid", int'(out_valid), 1);
        chk("tbl_hold_idx", int'(out_idx), 0);
        sb.push_back(0); sb.push_back(1); sb.push_back(9); sb.push_back(10); sb.push_back(11);
        out_ready = 1'b1;
        wait_drain("tbl_drain");

        // Single event latency
        reset_dut();
        sb.push_back(5);
        out_ready = 1'b1;
        capture(16'h0020);
        chk("single_pending", int'(pending), 16'h0020);
        chk("single_valid_k", int'(out_valid), 0);
        step();
        chk("single_valid_k1", int'(out_valid), 1);
        chk("single_idx", int'(out_idx), 5);
        step();
        chk("single_pending_after", int'(pending), 0);
        chk("single_valid_after", int'(out_valid), 0);

        // Round robin order and pointer
        reset_dut();
        out_ready = 1'b1;
        sb.push_back(0); sb.push_back(15);
        capture(16'h8001);
        wait_drain("rr_8001");
        sb.push_back(0);
        capture(16'h0001);
        wait_drain("rr_0001");
        sb.push_back(1); sb.push_back(0);
        capture(16'h0003);
        wait_drain("rr_0003");

        // Backpressure, overrun and recapture on the accept cycle
        reset_dut();
        capture(16'h0008);
        step();
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_idx", int'(out_idx), 3);
        capture(16'h0008);
        chk("bp_overrun", int'(overrun), 1);
        chk("bp_idx_held", int'(out_idx), 3);
        chk("bp_valid_held", int'(out_valid), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("bp_overrun_clr", int'(overrun), 0);
        sb.push_back(3); sb.push_back(3);
        out_ready = 1'b1;
        capture(16'h0008);
        chk("bp_recap_overrun", int'(overrun), 0);
        chk("bp_recap_pending", int'(pending), 16'h0008);
        chk("bp_recap_valid", int'(out_valid), 0);
        wait_drain("bp_drain");

        // Multi-hot capture
        reset_dut();
        out_ready = 1'b1;
        sb.push_back(4); sb.push_back(8);
        capture(16'h0110);
        chk("mh_multi", int'(multi_err), 1);
        chk("mh_pending", int'(pending), 16'h0110);
        wait_drain("mh_drain");
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("mh_clr", int'(multi_err), 0);

`ifdef ONEHOT_ENC_ERR_COUNT_EN
        // Saturating error counter
        sb_on = 1'b0;
        reset_dut();
        out_ready = 1'b1;
        d_in = 16'h0003; in_valid = 1'b1;
        repeat (300) step();
        d_in = '0; in_valid = 1'b0;
        chk("cnt_sat", int'(err_count), 255);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("cnt_clr", int'(err_count), 0);
`endif

        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
